// File: rtl/pc_fetch_sequencer.sv
// Program counter and fetch sequencer: IDLE/RUN/FLUSH/DONE control of the fetch address.
// Optional cycle counter built when PC_FETCH_CYCLE_COUNT_EN is defined.
module pc_fetch_sequencer #(
    parameter int              PC_W       = 16,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [PC_W-1:0] target,
    input  logic            take_branch,
    input  logic            stall,
    input  logic            halt,
    output logic [PC_W-1:0] pc,
    output logic            fetch_valid,
    output logic            done,
    output logic [15:0]     cycle_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc    <= START_ADDR;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        pc    <= START_ADDR;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // halt > stall > take_branch > sequential
                    if (halt) begin
                        state <= DONE;
                    end else if (stall) begin
                        state <= RUN;
                    end else if (take_branch) begin
                        pc    <= target;
                        state <= FLUSH;
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
                end
                FLUSH: state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

    assign fetch_valid = (state == RUN);
    assign done        = (state == DONE);

`ifdef PC_FETCH_CYCLE_COUNT_EN
    logic [15:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if ((state == IDLE || state == DONE) && start) begin
            cnt <= '0;
        end else if ((state == RUN || state == FLUSH) && cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign cycle_count = cnt;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Program-counter and fetch sequencer for the core. It sits directly downstream of the jump-target mux: it consumes the 16-bit target the mux resolves (either a direct jump operand or a jump-label table entry) and decides each cycle whether to load that target, advance sequentially, hold, or stop. It drives the instruction-memory address (`pc`), a fetch-valid strobe, a program-done flag and an optional cycle counter used by the test harness.

## Interface
Parameters:
- `PC_W`, 16, width of `pc` and `target`.
- `START_ADDR`, 0, value loaded into `pc` on reset and on `start`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin/restart a program run; sampled only in IDLE or DONE.
- `target`  in  PC_W  jump target from the jump-target mux.
- `take_branch`  in  1  load `target` into `pc` this cycle.
- `stall`  in  1  hold `pc` this cycle (memory/hazard hold).
- `halt`  in  1  current instruction is halt.
- `pc`  out  PC_W  instruction-memory address, registered.
- `fetch_valid`  out  1  high when `pc` addresses an instruction to be executed.
- `done`  out  1  high while the program has halted.
- `cycle_count`  out  16  executed-cycle counter (see Configuration).

## Operation
- States: IDLE, RUN, FLUSH, DONE. `fetch_valid` = (state==RUN); `done` = (state==DONE); both decoded from the state register only.
- Reset (async, immediate): state IDLE, `pc`=START_ADDR, `fetch_valid`=0, `done`=0, `cycle_count`=0.
- IDLE: `start`=1 -> `pc`<=START_ADDR, `cycle_count`<=0, state<=RUN. Otherwise hold.
- RUN: `take_branch`, `stall`, `halt` sampled every cycle; `start` ignored. Priority halt > stall > take_branch > sequential:
  - halt: `pc` held, state<=DONE.
  - stall: `pc` held, state stays RUN.
  - take_branch: `pc`<=`target`, state<=FLUSH.
  - else `pc`<=`pc`+1, modulo 2^PC_W (all-ones wraps to 0).
- FLUSH: exactly one cycle, `fetch_valid`=0 (bubble for the wrong-path fetch); all inputs ignored, `pc` held at the loaded target; state<=RUN unconditionally.
- DONE: `pc` held; `start`=1 -> same action as from IDLE (`pc`<=START_ADDR, count cleared, state<=RUN, `done` drops next cycle).
- `target` is used as-is, no width adjustment; bits above the jump mux's range arrive already zero-extended.

## Timing
- `start` sampled at edge N -> `fetch_valid`=1 and `pc`=START_ADDR during cycle N+1.
- Sequential fetch: one new `pc` per cycle, zero latency beyond the register.
- Taken branch at edge N -> `pc`=`target` from cycle N+1, `fetch_valid`=0 during cycle N+1, `fetch_valid`=1 at same `pc` during N+2, `pc`=`target`+1 during N+3 (absent stall).
- Halt at edge N -> `done`=1, `fetch_valid`=0 from cycle N+1.
- halt with take_branch or stall in the same cycle: halt wins, `pc` not updated.
- Reset mid-run: all outputs return to reset values asynchronously, no edge needed; deassertion returns to IDLE, never auto-restarts.

## Configuration
- `PC_FETCH_CYCLE_COUNT_EN` defined: `cycle_count` increments by 1 on every edge spent in RUN or FLUSH (stalls included), saturating at 0xFFFF; cleared on `start` and reset; frozen in DONE and IDLE.
- Undefined: counter logic not built, `cycle_count` tied to 0.

## Test plan
- Reset, `start` pulse, no other inputs -> `pc` = 0,1,2,3 on cycles 1-4 after start, `fetch_valid`=1 throughout, `done`=0.
- At `pc`=5 assert `take_branch` with `target`=0x0013 for one cycle -> next `pc`=0x0013 with `fetch_valid`=0 for one cycle, then 0x0013 valid, then 0x0014.
- At `pc`=7 hold `stall` 3 cycles -> `pc` stays 7 for 4 cycles, then 8; with macro defined `cycle_count` advanced by 4 over that span.
- At `pc`=9 assert `halt` and `take_branch` (`target`=0x004C) together -> `done`=1, `pc`=9, `fetch_valid`=0; then `start` -> `pc`=0, `done`=0, `cycle_count`=0.
- `START_ADDR`=0xFFFE, `start` -> `pc` = 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Assert `reset` between edges during RUN at `pc`=0x0025 -> `pc`=START_ADDR, `fetch_valid`=0, `cycle_count`=0 before the next edge; remains IDLE after release until `start`.
